// File: rtl/nios2_gpio_irq_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO interrupt PIO.
//   chipselect  : slave select
//   write_n     : active-low write strobe, qualified by chipselect
//   address     : register word address
//   writedata   : write data (only the low WIDTH bits are used by the slave)
//   readdata    : registered read data from the slave
`timescale 1ns/1ps
interface nios2_gpio_irq_pio_if;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write_n,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_gpio_irq_pio.sv
// GPIO input PIO with per-bit synchroniser, debounce filter, rise/fall
// edge capture and a maskable level/edge interrupt.
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous active-high reset
//   bus        : Avalon-MM slave (registers: 0 DATA, 1 RISE_EN, 2 IRQ_MASK,
//                3 EDGE_CAPTURE (W1C), 4 FALL_EN, 5 LEVEL_MODE, 6-7 zero)
//   in_port_i  : asynchronous external inputs
//   irq_o      : active-high level interrupt request
`timescale 1ns/1ps
module nios2_gpio_irq_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    nios2_gpio_irq_pio_if.slave   bus,
    input  logic [WIDTH-1:0]      in_port_i,
    output logic                  irq_o
);
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    genvar gi;

    // Synchroniser chain; the last stage is the synchronised input.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce: the filtered value only follows sync once sync has differed
    // from it for DEBOUNCE consecutive clocks.
    logic [WIDTH-1:0] filt;

    generate
        if (DEBOUNCE == 0) begin : g_nofilt
            assign filt = sync;
        end else begin : g_filt
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                logic [CW-1:0] cnt_q, cnt_d;
                logic          filt_q, filt_d;

                always_comb begin
                    cnt_d  = cnt_q;
                    filt_d = filt_q;
                    if (sync[gi] == filt_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                        filt_d = sync[gi];
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt_q  <= '0;
                        filt_q <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        filt_q <= filt_d;
                    end
                end

                assign filt[gi] = filt_q;
            end
        end
    endgenerate

    // Edge detection against a one-clock-delayed copy of filt.
    logic [WIDTH-1:0] filt_dly_q;
    logic [WIDTH-1:0] rise, fall;

    assign rise = filt & ~filt_dly_q;
    assign fall = ~filt & filt_dly_q;

    // Register file
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic             wr;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        level_d   = level_q;
        mask_d    = mask_q;
        clr       = '0;
        if (wr) begin
            case (bus.address)
                3'd1:    rise_en_d = wdata;
                3'd2:    mask_d    = wdata;
                3'd3:    clr       = wdata;
                3'd4:    fall_en_d = wdata;
                3'd5:    level_d   = wdata;
                default: ;
            endcase
        end
        // Set terms are OR-ed after the clear so a same-clock edge wins.
        cap_d = (cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Read mux is registered every clock, independent of chipselect.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            3'd0:    readdata_d[WIDTH-1:0] = filt;
            3'd1:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd2:    readdata_d[WIDTH-1:0] = mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = cap_q;
            3'd4:    readdata_d[WIDTH-1:0] = fall_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = level_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_dly_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            level_q    <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            filt_dly_q <= filt;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            level_q    <= level_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;

    // Level-mode bits report filt directly; others report the capture latch.
    assign irq_o = |(((level_q & filt) | (~level_q & cap_q)) & mask_q);

endmodule
